// File: rtl/addr8u_share_arb.sv
// addr8u_share_arb: two-requester round-robin arbiter time-sharing one external 8-bit unsigned adder.
// Optional swapped-operand recheck with bounded retries when ADDR8U_RECHECK_EN is defined.
module addr8u_share_arb #(
    parameter int RETRY_MAX = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic       req1_ready,
    output logic [7:0] add_a,
    output logic [7:0] add_b,
    input  logic [8:0] add_sum,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic [8:0] rsp_sum,
    output logic       rsp_err,
    input  logic       rsp_ready
);
`ifdef ADDR8U_RECHECK_EN
    typedef enum logic [1:0] {IDLE, EXEC, CHECK, RESP} state_t;
    localparam logic [2:0] RMAX = 3'(RETRY_MAX);
    logic [2:0] retry_q, retry_d;
    logic       err_q, err_d;
`else
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
`endif
    state_t     state_q, state_d;
    logic       rr_q, rr_d;
    logic [7:0] a_q, a_d, b_q, b_d;
    logic       id_q, id_d;
    logic [8:0] sum_q, sum_d;
    logic       gnt, idle;
    // Contention resolves by rr; otherwise whichever side is valid wins.
    assign gnt        = (req0_valid && req1_valid) ? rr_q : req1_valid;
    assign idle       = (state_q == IDLE) && !rst;
    assign req0_ready = idle && req0_valid && !gnt;
    assign req1_ready = idle && req1_valid && gnt;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = id_q;
    assign rsp_sum    = sum_q;
`ifdef ADDR8U_RECHECK_EN
    assign rsp_err    = err_q;
`else
    assign rsp_err    = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        a_d     = a_q;
        b_d     = b_q;
        id_d    = id_q;
        sum_d   = sum_q;
        add_a   = 8'h00;
        add_b   = 8'h00;
`ifdef ADDR8U_RECHECK_EN
        retry_d = retry_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: if (req0_ready || req1_ready) begin
                a_d     = gnt ? req1_a : req0_a;
                b_d     = gnt ? req1_b : req0_b;
                id_d    = gnt;
                state_d = EXEC;
`ifdef ADDR8U_RECHECK_EN
                retry_d = 3'd0;
                err_d   = 1'b0;
`endif
            end
            EXEC: begin
                add_a   = a_q;
                add_b   = b_q;
                sum_d   = add_sum;
`ifdef ADDR8U_RECHECK_EN
                state_d = CHECK;
`else
                state_d = RESP;
`endif
            end
`ifdef ADDR8U_RECHECK_EN
            // Swapped operands route through different adder bit paths.
            CHECK: begin
                add_a = b_q;
                add_b = a_q;
                if (add_sum == sum_q) begin
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (retry_q < RMAX) begin
                    retry_d = retry_q + 3'd1;
                    state_d = EXEC;
                end else begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
`endif
            RESP: if (rsp_ready) begin
                state_d = IDLE;
                rr_d    = ~id_q;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            id_q    <= 1'b0;
            sum_q   <= 9'h000;
`ifdef ADDR8U_RECHECK_EN
            retry_q <= 3'd0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            sum_q   <= sum_d;
`ifdef ADDR8U_RECHECK_EN
            retry_q <= retry_d;
            err_q   <= err_d;
`endif
        end
    end
endmodule

// File: tb/tb_addr8u_share_arb.sv
// tb_addr8u_share_arb: directed vectors for addr8u_share_arb with a behavioural shared adder.
module tb_addr8u_share_arb;
    localparam int RM = 2;
`ifdef ADDR8U_RECHECK_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    logic       clk = 0, rst = 0;
    logic       req0_valid = 0, req1_valid = 0, rsp_ready = 0, inj = 0;
    logic [7:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic       req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err;
    logic [7:0] add_a, add_b;
    logic [8:0] add_sum, rsp_sum;
    int         vecs = 0, errs = 0;

    addr8u_share_arb #(.RETRY_MAX(RM)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_err(rsp_err),
        .rsp_ready(rsp_ready)
    );

    // Fault injection: stuck-at-1 on bit 0 only while operands 02/04 are presented swapped.
    assign add_sum = ({1'b0, add_a} + {1'b0, add_b}) | {8'h00, inj && add_a == 8'h04 && add_b == 8'h02};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic wait_rsp(input int lat, input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (!rsp_valid && n < 20);
        chk(tag, 16'(n), 16'(lat));
    endtask

    initial begin
        #1 rst = 1;
        req0_valid = 1;
        req0_a = 8'hFF;
        req0_b = 8'h01;
        #2;
        chk("rst_ready0", 16'(req0_ready), 0);
        chk("rst_valid", 16'(rsp_valid), 0);
        chk("rst_add_a", 16'(add_a), 0);
        chk("rst_sum", 16'(rsp_sum), 0);
        step();
        step();
        rst = 0;
        rsp_ready = 1;
        #1;
        chk("t1_ready0", 16'(req0_ready), 1);
        chk("t1_ready1", 16'(req1_ready), 0);
        step();
        chk("t1_exec_a", 16'(add_a), 16'h00FF);
        chk("t1_exec_b", 16'(add_b), 16'h0001);
        chk("t1_exec_ready0", 16'(req0_ready), 0);
        req0_valid = 0;
        wait_rsp(LAT - 1, "t1_lat");
        chk("t1_sum", 16'(rsp_sum), 16'h0100);
        chk("t1_id", 16'(rsp_id), 0);
        chk("t1_err", 16'(rsp_err), 0);
        chk("t1_resp_a", 16'(add_a), 0);
        step();
        chk("t1_done", 16'(rsp_valid), 0);

        // Round-robin alternation starting from a fresh reset
        rst = 1;
        #1 rst = 0;
        rsp_ready = 0;
        req0_valid = 1; req0_a = 8'h10; req0_b = 8'h20;
        req1_valid = 1; req1_a = 8'h30; req1_b = 8'h40;
        #1;
        chk("rr_first0", 16'(req0_ready), 1);
        chk("rr_first1", 16'(req1_ready), 0);
        step();
        req0_valid = 0;
        wait_rsp(LAT - 1, "rr_lat0");
        chk("rr_id0", 16'(rsp_id), 0);
        chk("rr_sum0", 16'(rsp_sum), 16'h0030);
        chk("rr_resp_ready1", 16'(req1_ready), 0);
        rsp_ready = 1;
        #1;
        chk("rr_hs_ready1", 16'(req1_ready), 0);
        step();
        chk("rr_idle_valid", 16'(rsp_valid), 0);
        chk("rr_idle_ready1", 16'(req1_ready), 1);
        step();
        req1_valid = 0;
        wait_rsp(LAT - 1, "rr_lat1");
        chk("rr_id1", 16'(rsp_id), 1);
        chk("rr_sum1", 16'(rsp_sum), 16'h0070);
        step();
        req0_valid = 1; req0_a = 8'h01; req0_b = 8'h02;
        req1_valid = 1; req1_a = 8'h03; req1_b = 8'h04;
        #1;
        chk("rr_third0", 16'(req0_ready), 1);
        chk("rr_third1", 16'(req1_ready), 0);
        step();
        req0_valid = 0;
        wait_rsp(LAT - 1, "rr_lat2");
        chk("rr_sum2", 16'(rsp_sum), 16'h0003);
        step();
        req0_valid = 1;
        #1;
        chk("rr_fourth1", 16'(req1_ready), 1);
        chk("rr_fourth0", 16'(req0_ready), 0);
        step();
        req0_valid = 0;
        req1_valid = 0;
        wait_rsp(LAT - 1, "rr_lat3");
        chk("rr_id3", 16'(rsp_id), 1);
        chk("rr_sum3", 16'(rsp_sum), 16'h0007);
        step();

        // Backpressure: response held for 5 cycles with another requester waiting
        rsp_ready = 0;
        req0_valid = 1; req0_a = 8'hC8; req0_b = 8'h64;
        step();
        req0_valid = 0;
        wait_rsp(LAT - 1, "bp_lat");
        req1_valid = 1; req1_a = 8'h03; req1_b = 8'h04;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", 16'(rsp_valid), 1);
            chk("bp_sum", 16'(rsp_sum), 16'h012C);
            chk("bp_id", 16'(rsp_id), 0);
            chk("bp_ready0", 16'(req0_ready), 0);
            chk("bp_ready1", 16'(req1_ready), 0);
        end
        rsp_ready = 1;
        #1;
        chk("bp_hs_ready1", 16'(req1_ready), 0);
        step();
        chk("bp_idle_ready1", 16'(req1_ready), 1);
        step();
        req1_valid = 0;
        wait_rsp(LAT - 1, "bp_lat1");
        chk("bp_sum1", 16'(rsp_sum), 16'h0007);
        chk("bp_id1", 16'(rsp_id), 1);
        step();

        // Reset during EXEC after rr has moved to requester 1
        req0_valid = 1; req0_a = 8'h11; req0_b = 8'h22;
        step();
        req0_valid = 0;
        wait_rsp(LAT - 1, "mr_lat");
        step();
        req0_valid = 1; req0_a = 8'h55; req0_b = 8'h66;
        req1_valid = 1; req1_a = 8'h77; req1_b = 8'h88;
        #1;
        chk("mr_pre_ready1", 16'(req1_ready), 1);
        step();
        chk("mr_exec_a", 16'(add_a), 16'h0077);
        rst = 1;
        #1;
        chk("mr_valid", 16'(rsp_valid), 0);
        chk("mr_add_a", 16'(add_a), 0);
        chk("mr_add_b", 16'(add_b), 0);
        chk("mr_ready0", 16'(req0_ready), 0);
        chk("mr_ready1", 16'(req1_ready), 0);
        chk("mr_sum", 16'(rsp_sum), 0);
        chk("mr_id", 16'(rsp_id), 0);
        req0_valid = 0;
        req1_valid = 0;
        step();
        rst = 0;
        step();
        chk("mr_no_rsp_a", 16'(rsp_valid), 0);
        step();
        chk("mr_no_rsp_b", 16'(rsp_valid), 0);
        req0_valid = 1;
        req1_valid = 1;
        #1;
        chk("mr_after_ready0", 16'(req0_ready), 1);
        step();
        req0_valid = 0;
        req1_valid = 0;
        wait_rsp(LAT - 1, "mr_after_lat");
        chk("mr_after_id", 16'(rsp_id), 0);
        chk("mr_after_sum", 16'(rsp_sum), 16'h00BB);
        step();

        // Idle with nothing valid: adder inputs parked at zero
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_add_a", 16'(add_a), 0);
            chk("idle_add_b", 16'(add_b), 0);
            chk("idle_valid", 16'(rsp_valid), 0);
        end

`ifdef ADDR8U_RECHECK_EN
        inj = 1;
        req0_valid = 1; req0_a = 8'h02; req0_b = 8'h04;
        step();
        req0_valid = 0;
        wait_rsp(LAT - 1 + 2 * RM, "rc_lat");
        chk("rc_err", 16'(rsp_err), 1);
        chk("rc_sum", 16'(rsp_sum), 16'h0006);
        step();
        inj = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
